// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// requester A (ALU writeback) and requester B (memory load), with an optional post-reset zero-clear.
module regfile_write_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] wadd_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] wadd_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_wadd,
  output logic [DATA_W-1:0] rf_in,
  output logic              init_busy
);

  localparam logic [ADDR_W:0] NREGS = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {
    INIT,
    ARB
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W:0]   clr_cnt, clr_cnt_next;
  logic              ptr_b, ptr_b_next;
  logic              gnt_a_next, gnt_b_next, rf_write_next, init_busy_next;
  logic [ADDR_W-1:0] rf_wadd_next;
  logic [DATA_W-1:0] rf_in_next;
  logic              elig_a, elig_b, grant_a, grant_b, clr_done;

  // A requester granted last cycle sits out one cycle so a still-high req is not granted twice
  assign elig_a   = req_a & ~gnt_a;
  assign elig_b   = req_b & ~gnt_b;
  assign grant_a  = elig_a & (~elig_b | ~ptr_b);
  assign grant_b  = elig_b & (~elig_a |  ptr_b);
  assign clr_done = !INIT_CLEAR || (clr_cnt == NREGS);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= INIT;
      clr_cnt   <= '0;
      ptr_b     <= 1'b0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      rf_write  <= 1'b1;
      rf_wadd   <= '0;
      rf_in     <= '0;
      init_busy <= 1'b1;
    end else begin
      state     <= state_next;
      clr_cnt   <= clr_cnt_next;
      ptr_b     <= ptr_b_next;
      gnt_a     <= gnt_a_next;
      gnt_b     <= gnt_b_next;
      rf_write  <= rf_write_next;
      rf_wadd   <= rf_wadd_next;
      rf_in     <= rf_in_next;
      init_busy <= init_busy_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    ptr_b_next   = ptr_b;
    case (state)
      INIT: begin
        if (clr_done) begin
          state_next = ARB;
        end else begin
          clr_cnt_next = clr_cnt + 1'b1;
        end
      end
      ARB: begin
        if (grant_a) begin
          ptr_b_next = 1'b1;
        end else if (grant_b) begin
          ptr_b_next = 1'b0;
        end
      end
      default: state_next = INIT;
    endcase
  end

  // Address and data hold their last values whenever the port is idle
  always_comb begin
    gnt_a_next     = 1'b0;
    gnt_b_next     = 1'b0;
    rf_write_next  = 1'b1;
    rf_wadd_next   = rf_wadd;
    rf_in_next     = rf_in;
    init_busy_next = 1'b1;
    case (state)
      INIT: begin
        init_busy_next = !clr_done;
        if (!clr_done) begin
          rf_write_next = 1'b0;
          rf_wadd_next  = clr_cnt[ADDR_W-1:0];
          rf_in_next    = '0;
        end
      end
      ARB: begin
        init_busy_next = 1'b0;
        if (grant_a) begin
          gnt_a_next    = 1'b1;
          rf_write_next = 1'b0;
          rf_wadd_next  = wadd_a;
          rf_in_next    = wdata_a;
        end else if (grant_b) begin
          gnt_b_next    = 1'b1;
          rf_write_next = 1'b0;
          rf_wadd_next  = wadd_b;
          rf_in_next    = wdata_b;
        end
      end
      default: init_busy_next = 1'b1;
    endcase
  end

endmodule
